// File: rtl/ofs_fim_pcie_pkg.sv
// ---------------------------------------------------------------------------
// ofs_fim_pcie_pkg
// Shared types for the PCIe FLR sequencer slice.
//   t_flr_func      : identity of one PCIe function {vf_active, vf, pf}
//   t_flr_seq_state : FLR sequencer FSM states
//   sat_inc8        : 8-bit saturating increment helper
// ---------------------------------------------------------------------------
package ofs_fim_pcie_pkg;

    localparam int FLR_PF_W = 3;
    localparam int FLR_VF_W = 11;

    typedef struct packed {
        logic                vf_active;
        logic [FLR_VF_W-1:0] vf;
        logic [FLR_PF_W-1:0] pf;
    } t_flr_func;

    typedef enum logic [1:0] {
        FLR_IDLE   = 2'd0,
        FLR_ASSERT = 2'd1,
        FLR_RSP    = 2'd2
    } t_flr_seq_state;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pcie_flr_req_fifo.sv
// ---------------------------------------------------------------------------
// pcie_flr_req_fifo
// Show-ahead synchronous FIFO of pending FLR targets.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write strobe and entry (ignored when full unless popping)
//   pop        : consume head entry (ignored when empty)
//   dout       : current head entry, valid whenever empty=0
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module pcie_flr_req_fifo
    import ofs_fim_pcie_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  t_flr_func din,
    input  logic      pop,
    output t_flr_func dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    t_flr_func       mem_q [DEPTH];
    t_flr_func       mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_ok_s, pop_ok_s;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == (AW+1)'(0));
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: a pop in the same cycle frees a slot, so a push while full is still accepted.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pcie_flr_sequencer.sv
// ---------------------------------------------------------------------------
// pcie_flr_sequencer
// Serialises PCIe FLR requests into one-at-a-time reset handshakes with the
// function reset fabric and returns one completion per request, in order.
//   csr_clk, csr_rst_n        : clock, synchronous active-low reset
//   flr_req_*                 : one-cycle FLR request strobe + target
//   flr_rsp_*                 : one-cycle completion strobe + echoed target
//   func_rst_req/_pf/_vf/_vf_active : level reset request + stable target
//   func_rst_ack              : target quiesced (only meaningful while req=1)
//   q_overflow                : sticky, a request was dropped (queue full)
//   timeout_cnt               : saturating count of forced completions
//   busy                      : request in flight or queued
// ---------------------------------------------------------------------------
module pcie_flr_sequencer
    import ofs_fim_pcie_pkg::*;
#(
    parameter int QDEPTH      = 8,
    parameter int HOLD_CYC    = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int PF_W        = FLR_PF_W,
    parameter int VF_W        = FLR_VF_W
) (
    input  logic            csr_clk,
    input  logic            csr_rst_n,
    input  logic            flr_req_valid,
    input  logic [PF_W-1:0] flr_req_pf,
    input  logic [VF_W-1:0] flr_req_vf,
    input  logic            flr_req_vf_active,
    output logic            flr_rsp_valid,
    output logic [PF_W-1:0] flr_rsp_pf,
    output logic [VF_W-1:0] flr_rsp_vf,
    output logic            flr_rsp_vf_active,
    output logic            func_rst_req,
    output logic [PF_W-1:0] func_rst_pf,
    output logic [VF_W-1:0] func_rst_vf,
    output logic            func_rst_vf_active,
    input  logic            func_rst_ack,
    output logic            q_overflow,
    output logic [7:0]      timeout_cnt,
    output logic            busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    t_flr_seq_state  state_q, state_d;
    t_flr_func       tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            ack_seen_q, ack_seen_d;
    logic            func_rst_req_q, func_rst_req_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            q_overflow_q, q_overflow_d;
    logic [7:0]      timeout_cnt_q, timeout_cnt_d;

    t_flr_func       req_func_s;
    t_flr_func       head_s;
    logic            fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic            ack_hit_s;

    assign req_func_s.pf        = flr_req_pf;
    assign req_func_s.vf        = flr_req_vf;
    assign req_func_s.vf_active = flr_req_vf_active;

    // Head is consumed in the IDLE cycle; the target register loads it on the same edge.
    assign fifo_pop_s = (state_q == FLR_IDLE) && !fifo_empty_s;

    pcie_flr_req_fifo #(
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk   (csr_clk),
        .rst_n (csr_rst_n),
        .push  (flr_req_valid),
        .din   (req_func_s),
        .pop   (fifo_pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FSM next-state, hold/timeout counting and statistics.
    always_comb begin
        state_d        = state_q;
        tgt_d          = tgt_q;
        cnt_d          = cnt_q;
        ack_seen_d     = ack_seen_q;
        func_rst_req_d = func_rst_req_q;
        rsp_valid_d    = 1'b0;
        timeout_cnt_d  = timeout_cnt_q;
        // An early ack is remembered so the exit can wait for the hold time.
        ack_hit_s      = func_rst_ack || ack_seen_q;
        q_overflow_d   = q_overflow_q | (flr_req_valid && fifo_full_s && !fifo_pop_s);

        case (state_q)
            FLR_IDLE: begin
                if (!fifo_empty_s) begin
                    tgt_d          = head_s;
                    cnt_d          = '0;
                    ack_seen_d     = 1'b0;
                    func_rst_req_d = 1'b1;
                    state_d        = FLR_ASSERT;
                end else begin
                    state_d = FLR_IDLE;
                end
            end
            FLR_ASSERT: begin
                cnt_d      = cnt_q + CNT_W'(1);
                ack_seen_d = ack_hit_s;
                if (ack_hit_s && (cnt_q >= CNT_W'(HOLD_CYC - 1))) begin
                    func_rst_req_d = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = FLR_RSP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_cnt_d  = sat_inc8(timeout_cnt_q);
                    func_rst_req_d = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = FLR_RSP;
                end else begin
                    state_d = FLR_ASSERT;
                end
            end
            FLR_RSP: begin
                func_rst_req_d = 1'b0;
                state_d        = FLR_IDLE;
            end
            default: begin
                func_rst_req_d = 1'b0;
                state_d        = FLR_IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge csr_clk) begin
        if (!csr_rst_n) begin
            state_q        <= FLR_IDLE;
            tgt_q          <= '0;
            cnt_q          <= '0;
            ack_seen_q     <= 1'b0;
            func_rst_req_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            q_overflow_q   <= 1'b0;
            timeout_cnt_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            cnt_q          <= cnt_d;
            ack_seen_q     <= ack_seen_d;
            func_rst_req_q <= func_rst_req_d;
            rsp_valid_q    <= rsp_valid_d;
            q_overflow_q   <= q_overflow_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    // Target register only changes in IDLE, so it is stable through ASSERT and RSP.
    assign func_rst_req       = func_rst_req_q;
    assign func_rst_pf        = tgt_q.pf;
    assign func_rst_vf        = tgt_q.vf;
    assign func_rst_vf_active = tgt_q.vf_active;
    assign flr_rsp_valid      = rsp_valid_q;
    assign flr_rsp_pf         = tgt_q.pf;
    assign flr_rsp_vf         = tgt_q.vf;
    assign flr_rsp_vf_active  = tgt_q.vf_active;
    assign q_overflow         = q_overflow_q;
    assign timeout_cnt        = timeout_cnt_q;
    assign busy               = (state_q != FLR_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_pcie_flr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pcie_flr_sequencer
// Directed stimulus with a completion scoreboard: each issued request pushes
// its expected completion; a monitor pops and compares on flr_rsp_valid.
// ---------------------------------------------------------------------------
module tb_pcie_flr_sequencer;

    typedef struct packed {
        logic        vfa;
        logic [10:0] vf;
        logic [2:0]  pf;
    } exp_t;

    logic        csr_clk = 1'b0;
    logic        csr_rst_n;
    logic        flr_req_valid;
    logic [2:0]  flr_req_pf;
    logic [10:0] flr_req_vf;
    logic        flr_req_vf_active;
    logic        flr_rsp_valid;
    logic [2:0]  flr_rsp_pf;
    logic [10:0] flr_rsp_vf;
    logic        flr_rsp_vf_active;
    logic        func_rst_req;
    logic [2:0]  func_rst_pf;
    logic [10:0] func_rst_vf;
    logic        func_rst_vf_active;
    logic        func_rst_ack;
    logic        q_overflow;
    logic [7:0]  timeout_cnt;
    logic        busy;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   rsp_cnt  = 0;
    exp_t exp_q[$];
    exp_t e_mon;
    exp_t tgt_rise;
    logic req_prev;
    int   low_run;

    always #5 csr_clk = ~csr_clk;

    pcie_flr_sequencer dut (
        .csr_clk            (csr_clk),
        .csr_rst_n          (csr_rst_n),
        .flr_req_valid      (flr_req_valid),
        .flr_req_pf         (flr_req_pf),
        .flr_req_vf         (flr_req_vf),
        .flr_req_vf_active  (flr_req_vf_active),
        .flr_rsp_valid      (flr_rsp_valid),
        .flr_rsp_pf         (flr_rsp_pf),
        .flr_rsp_vf         (flr_rsp_vf),
        .flr_rsp_vf_active  (flr_rsp_vf_active),
        .func_rst_req       (func_rst_req),
        .func_rst_pf        (func_rst_pf),
        .func_rst_vf        (func_rst_vf),
        .func_rst_vf_active (func_rst_vf_active),
        .func_rst_ack       (func_rst_ack),
        .q_overflow         (q_overflow),
        .timeout_cnt        (timeout_cnt),
        .busy               (busy)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    // Completion monitor: every response must match the oldest outstanding request.
    always @(negedge csr_clk) begin
        if (flr_rsp_valid === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("rsp_pf",  32'(flr_rsp_pf),        32'(e_mon.pf));
                check("rsp_vf",  32'(flr_rsp_vf),        32'(e_mon.vf));
                check("rsp_vfa", 32'(flr_rsp_vf_active), 32'(e_mon.vfa));
            end
        end
    end

    // Reset-request monitor: gap of at least two low cycles between functions, stable target.
    always @(negedge csr_clk) begin
        if (csr_rst_n !== 1'b1) begin
            req_prev = 1'b0;
            low_run  = 100;
        end else if (func_rst_req === 1'b1 && !req_prev) begin
            check("req_gap", 32'(low_run >= 2), 32'd1);
            tgt_rise = '{func_rst_vf_active, func_rst_vf, func_rst_pf};
            req_prev = 1'b1;
            low_run  = 0;
        end else if (func_rst_req !== 1'b1 && req_prev) begin
            check("tgt_stable", 32'({func_rst_vf_active, func_rst_vf, func_rst_pf}), 32'(tgt_rise));
            req_prev = 1'b0;
            low_run  = 1;
        end else if (func_rst_req !== 1'b1) begin
            low_run++;
        end
    end

    task automatic tick();
        @(posedge csr_clk);
        #1;
    endtask

    task automatic send(input logic [2:0] pf, input logic [10:0] vf, input logic vfa, input bit expect_rsp);
        flr_req_valid     = 1'b1;
        flr_req_pf        = pf;
        flr_req_vf        = vf;
        flr_req_vf_active = vfa;
        if (expect_rsp) begin
            exp_q.push_back('{vfa, vf, pf});
        end
        tick();
        flr_req_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (func_rst_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(func_rst_req), 32'd1);
    endtask

    // Counts cycles func_rst_req stays high; raises ack on the given observed cycle (0 = never).
    task automatic hold_len(input int ack_at, output int held);
        held = 0;
        while (func_rst_req === 1'b1 && held < 5000) begin
            held++;
            if (held == ack_at) begin
                func_rst_ack = 1'b1;
            end
            tick();
        end
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int held;
        int n;
        csr_rst_n         = 1'b0;
        flr_req_valid     = 1'b0;
        flr_req_pf        = 3'd0;
        flr_req_vf        = 11'd0;
        flr_req_vf_active = 1'b0;
        func_rst_ack      = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_req",     32'(func_rst_req),  32'd0);
        check("rst_rsp",     32'(flr_rsp_valid), 32'd0);
        check("rst_ovf",     32'(q_overflow),    32'd0);
        check("rst_tocnt",   32'(timeout_cnt),   32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        csr_rst_n = 1'b1;
        tick();

        // 1: PF FLR, ack three cycles into the hold -> held for the full 16 cycles
        send(3'd0, 11'd0, 1'b0, 1'b1);
        wait_req("t1_req_start");
        hold_len(4, held);
        check("t1_hold", 32'(held), 32'd16);
        check("t1_rsp_valid", 32'(flr_rsp_valid), 32'd1);
        func_rst_ack = 1'b0;
        repeat (3) tick();
        check("t1_rsp_cnt", 32'(rsp_cnt), 32'd1);

        // 2: VF FLR, no ack -> forced completion after TIMEOUT_CYC
        send(3'd1, 11'd5, 1'b1, 1'b1);
        wait_req("t2_req_start");
        check("t2_tgt_vf", 32'(func_rst_vf), 32'd5);
        check("t2_tgt_vfa", 32'(func_rst_vf_active), 32'd1);
        hold_len(0, held);
        check("t2_hold", 32'(held), 32'd4096);
        check("t2_tocnt", 32'(timeout_cnt), 32'd1);
        repeat (3) tick();
        check("t2_rsp_cnt", 32'(rsp_cnt), 32'd2);

        // 3: three back-to-back strobes, ack held high
        func_rst_ack = 1'b1;
        send(3'd0, 11'd0, 1'b1, 1'b1);
        send(3'd0, 11'd1, 1'b1, 1'b1);
        send(3'd0, 11'd2, 1'b1, 1'b1);
        drain("t3_drain", 200);
        check("t3_rsp_cnt", 32'(rsp_cnt), 32'd5);
        check("t3_tocnt", 32'(timeout_cnt), 32'd1);
        func_rst_ack = 1'b0;
        tick();

        // 4: nine requests fill in-flight + 8 queue slots; tenth is dropped
        for (int i = 0; i < 9; i++) begin
            send(3'd2, 11'(i), 1'b1, 1'b1);
        end
        check("t4_no_ovf", 32'(q_overflow), 32'd0);
        send(3'd2, 11'd99, 1'b1, 1'b0);
        check("t4_ovf", 32'(q_overflow), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);

        // 5: reset mid-ASSERT with entries queued -> clean slate, no completions afterwards
        repeat (2) tick();
        check("t5_in_assert", 32'(func_rst_req), 32'd1);
        csr_rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("t5_req",   32'(func_rst_req),  32'd0);
        check("t5_rsp",   32'(flr_rsp_valid), 32'd0);
        check("t5_ovf",   32'(q_overflow),    32'd0);
        check("t5_tocnt", 32'(timeout_cnt),   32'd0);
        check("t5_busy",  32'(busy),          32'd0);
        check("t5_tgt",   32'({func_rst_vf_active, func_rst_vf, func_rst_pf}), 32'd0);
        csr_rst_n    = 1'b1;
        func_rst_ack = 1'b1;
        repeat (30) tick();
        check("t5_no_rsp", 32'(rsp_cnt), 32'd5);
        check("t5_idle",   32'(busy),    32'd0);
        func_rst_ack = 1'b0;

        // 6: push in the same cycle as a pop while full -> accepted, no overflow
        for (int i = 0; i < 9; i++) begin
            send(3'd4, 11'(i), 1'b0, 1'b1);
        end
        check("t6_no_ovf_full", 32'(q_overflow), 32'd0);
        func_rst_ack = 1'b1;
        n = 0;
        while (flr_rsp_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t6_rsp_seen", 32'(flr_rsp_valid), 32'd1);
        tick();
        send(3'd5, 11'd3, 1'b1, 1'b1);
        check("t6_no_ovf", 32'(q_overflow), 32'd0);
        drain("t6_drain", 400);
        check("t6_rsp_cnt", 32'(rsp_cnt), 32'd15);
        func_rst_ack = 1'b0;
        repeat (3) tick();
        check("t6_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
